// File: rtl/vga_timing_pkg.sv
// Shared timing constants, region decode and sync-bundle helpers for the VGA output stage.
// Defaults describe 640x480@60 with a 25 MHz pixel clock.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int unsigned H_CNT_W = 11;
    localparam int unsigned V_CNT_W = 10;

    typedef enum logic [1:0] {
        REGION_ACTIVE,
        REGION_FP,
        REGION_SYNC,
        REGION_BP
    } region_e;

    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } syncBundle_t;

    function automatic region_e decodeRegion(
        input int unsigned pos,
        input int unsigned activeLen,
        input int unsigned fpLen,
        input int unsigned syncLen
    );
        region_e region;
        if (pos < activeLen) begin
            region = REGION_ACTIVE;
        end else if (pos < activeLen + fpLen) begin
            region = REGION_FP;
        end else if (pos < activeLen + fpLen + syncLen) begin
            region = REGION_SYNC;
        end else begin
            region = REGION_BP;
        end
        return region;
    endfunction

    function automatic syncBundle_t syncIdle(input bit hsPol, input bit vsPol);
        syncBundle_t idle;
        idle.hs     = ~hsPol;
        idle.vs     = ~vsPol;
        idle.active = 1'b0;
        return idle;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Raster h/v counters with registered request/position/frame-start outputs and
// raw (unaligned) sync/blank flags describing the same counter position.
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic               iCLK,
    input  logic               iRST,
    output logic               oRequest,
    output logic [H_CNT_W-1:0] oX,
    output logic [V_CNT_W-1:0] oY,
    output logic               oFrameStart,
    output syncBundle_t        oSyncRaw
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [H_CNT_W-1:0] H_LAST = H_CNT_W'(H_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] V_LAST = V_CNT_W'(V_TOTAL - 1);

    logic [H_CNT_W-1:0] hCnt;
    logic [V_CNT_W-1:0] vCnt;
    logic [H_CNT_W-1:0] hNext;
    logic [V_CNT_W-1:0] vNext;
    logic               hWrap;
    region_e            hRegion;
    region_e            vRegion;
    syncBundle_t        syncNext;
    logic               frameStartNext;

    // Outputs are computed from the next counter value so that, once registered,
    // they describe the counter position of the same cycle.
    always_comb begin
        hWrap = (hCnt == H_LAST);
        hNext = hWrap ? '0 : hCnt + H_CNT_W'(1);
        vNext = vCnt;
        if (hWrap) begin
            vNext = (vCnt == V_LAST) ? '0 : vCnt + V_CNT_W'(1);
        end

        hRegion = decodeRegion(32'(hNext), H_ACTIVE, H_FP, H_SYNC);
        vRegion = decodeRegion(32'(vNext), V_ACTIVE, V_FP, V_SYNC);

        syncNext.hs     = (hRegion == REGION_SYNC) ? HS_POL : ~HS_POL;
        syncNext.vs     = (vRegion == REGION_SYNC) ? VS_POL : ~VS_POL;
        syncNext.active = (hRegion == REGION_ACTIVE) && (vRegion == REGION_ACTIVE);

        frameStartNext = (hNext == '0) && (vNext == '0);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            hCnt        <= H_LAST;
            vCnt        <= V_LAST;
            oRequest    <= 1'b0;
            oX          <= '0;
            oY          <= '0;
            oFrameStart <= 1'b0;
            oSyncRaw    <= syncIdle(HS_POL, VS_POL);
        end else begin
            hCnt        <= hNext;
            vCnt        <= vNext;
            oRequest    <= syncNext.active;
            oX          <= hNext;
            oY          <= vNext;
            oFrameStart <= frameStartNext;
            oSyncRaw    <= syncNext;
        end
    end

endmodule

// File: rtl/vga_timing_out.sv
// VGA output stage: raster timing, one-cycle-ahead pixel request, and DAC pin
// registers with sync/blank aligned to the returned pixel (fixed latency 2).
module vga_timing_out
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned IN_W     = 10,
    parameter int unsigned OUT_W    = 8
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [IN_W-1:0]    iRed,
    input  logic [IN_W-1:0]    iGreen,
    input  logic [IN_W-1:0]    iBlue,
    output logic               oRequest,
    output logic [H_CNT_W-1:0] oX,
    output logic [V_CNT_W-1:0] oY,
    output logic               oFrameStart,
    output logic [OUT_W-1:0]   oVGA_R,
    output logic [OUT_W-1:0]   oVGA_G,
    output logic [OUT_W-1:0]   oVGA_B,
    output logic               oVGA_HS,
    output logic               oVGA_VS,
    output logic               oVGA_BLANK_N,
    output logic               oVGA_SYNC_N
);

    syncBundle_t      syncRaw;
    syncBundle_t      syncD1;
    logic [OUT_W-1:0] redTrunc;
    logic [OUT_W-1:0] greenTrunc;
    logic [OUT_W-1:0] blueTrunc;
    logic             unusedColourLsbs;

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL)
    ) syncCounter (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .oRequest    (oRequest),
        .oX          (oX),
        .oY          (oY),
        .oFrameStart (oFrameStart),
        .oSyncRaw    (syncRaw)
    );

    // MSB truncation; the dropped LSBs are intentionally discarded.
    assign redTrunc         = iRed[IN_W-1 -: OUT_W];
    assign greenTrunc       = iGreen[IN_W-1 -: OUT_W];
    assign blueTrunc        = iBlue[IN_W-1 -: OUT_W];
    assign unusedColourLsbs = ^{iRed, iGreen, iBlue};

    assign oVGA_SYNC_N = 1'b0;

    // syncD1 lines the flags up with the pixel arriving from upstream; the pin
    // registers then capture flags and pixel together.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            syncD1       <= syncIdle(HS_POL, VS_POL);
            oVGA_R       <= '0;
            oVGA_G       <= '0;
            oVGA_B       <= '0;
            oVGA_HS      <= ~HS_POL;
            oVGA_VS      <= ~VS_POL;
            oVGA_BLANK_N <= 1'b0;
        end else begin
            syncD1       <= syncRaw;
            oVGA_R       <= syncD1.active ? redTrunc   : '0;
            oVGA_G       <= syncD1.active ? greenTrunc : '0;
            oVGA_B       <= syncD1.active ? blueTrunc  : '0;
            oVGA_HS      <= syncD1.hs;
            oVGA_VS      <= syncD1.vs;
            oVGA_BLANK_N <= syncD1.active;
        end
    end

endmodule
